fb_fetch_arbiter: RTL and testbench

Arbitrates a single-port framebuffer memory between display line prefetch and a pixel-writer requester, scheduled from the `xvga` timing counters. During each horizontal blank before an active line, it bursts that line's words into the idle bank of an external double-buffered line buffer. It grants the memory to the writer at all other times. The block sits between the timing generator, the framebuffer RAM, the line buffer and the pixel-update logic.

---
 rtl/fb_fetch_arbiter_if.sv | 28 ++
 rtl/fb_fetch_arbiter.sv | 111 +++++++++++
 tb/tb_fb_fetch_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/fb_fetch_arbiter_if.sv
// fb_fetch_arbiter_if: pixel-writer, framebuffer-memory and line-buffer signals of the fetch arbiter
//   slave  : arbiter side (takes wr_req/wr_addr/wr_data/mem_rdata, drives the rest)
//   master : surrounding logic side (writer, RAM model, line buffer)
interface fb_fetch_arbiter_if #(
  parameter int ADDR_W   = 20,
  parameter int DATA_W   = 32,
  parameter int LOG2_WPL = 8
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              lb_we;
  logic [LOG2_WPL:0] lb_waddr;
  logic [DATA_W-1:0] lb_wdata;
  modport slave (
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, mem_addr, mem_we, mem_wdata, lb_we, lb_waddr, lb_wdata
  );
  modport master (
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, mem_addr, mem_we, mem_wdata, lb_we, lb_waddr, lb_wdata
  );
endinterface

// File: rtl/fb_fetch_arbiter.sv
// fb_fetch_arbiter: shares one framebuffer RAM port between line prefetch (in hblank) and a pixel writer
//   vclock, reset  : pixel clock, synchronous active-high reset
//   hcount, vcount : xvga timing counters
//   bus (slave)    : writer handshake, registered RAM port, line-buffer write port
//   disp_bank      : line-buffer bank the display reads this line
//   fetch_late     : sticky overrun flag, built only with FB_FETCH_CHECK_EN defined (else tied 0)
module fb_fetch_arbiter #(
  parameter int H_ACTIVE    = 1024,
  parameter int H_TOTAL     = 1344,
  parameter int V_ACTIVE    = 768,
  parameter int V_TOTAL     = 806,
  parameter int FETCH_START = 1024,
  parameter int LOG2_WPL    = 8,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int BASE_ADDR   = 0,
  parameter int RD_LAT      = 2
) (
  input  logic              vclock,
  input  logic              reset,
  input  logic [10:0]       hcount,
  input  logic [10:0]       vcount,
  fb_fetch_arbiter_if.slave bus,
  output logic              disp_bank,
  output logic              fetch_late
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state;
  logic [LOG2_WPL-1:0] i, idx;
  logic fill_bank, line_ready, trigger, issue, grant, wrap;
  logic [2:0] drain_cnt;
  logic [RD_LAT:0] pv;
  logic [RD_LAT:0][LOG2_WPL-1:0] pi;
  logic [10:0] nl;
  logic [ADDR_W-1:0] rd_addr;
  if (RD_LAT < 1 || RD_LAT > 4 || FETCH_START < H_ACTIVE || FETCH_START >= H_TOTAL) begin : g_bad_cfg
    $error("fb_fetch_arbiter: RD_LAT must be 1..4 and FETCH_START must lie in horizontal blank");
  end
  assign nl      = (vcount == 11'(V_TOTAL - 1)) ? 11'd0 : vcount + 11'd1;
  assign wrap    = hcount == 11'(H_TOTAL - 1);
  assign trigger = state == IDLE && hcount == 11'(FETCH_START) && nl < 11'(V_ACTIVE);
  assign issue   = trigger || state == FETCH;
  assign grant   = state == IDLE && !trigger && bus.wr_req;
  // word 0 is issued on the trigger edge itself so the first read address appears one clock later
  assign idx     = trigger ? '0 : i;
  assign rd_addr = ADDR_W'(BASE_ADDR) + (ADDR_W'(nl) << LOG2_WPL) + ADDR_W'(idx);
  // pv/pi track each issued read so the line-buffer strobe lines up with mem_rdata RD_LAT clocks later
  assign bus.lb_we    = pv[RD_LAT];
  assign bus.lb_waddr = {fill_bank, pi[RD_LAT]};
  assign bus.lb_wdata = bus.lb_we ? bus.mem_rdata : '0;
  always_ff @(posedge vclock) begin
    if (reset) begin
      state         <= IDLE;
      i             <= '0;
      fill_bank     <= 1'b0;
      line_ready    <= 1'b0;
      drain_cnt     <= '0;
      pv            <= '0;
      pi            <= '0;
      disp_bank     <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
      bus.wr_ack    <= 1'b0;
    end else begin
      pv         <= {pv[RD_LAT-1:0], issue};
      pi         <= {pi[RD_LAT-1:0], idx};
      bus.mem_we <= grant;
      bus.wr_ack <= grant;
      if (issue) bus.mem_addr <= rd_addr;
      else if (grant) begin
        bus.mem_addr  <= bus.wr_addr;
        bus.mem_wdata <= bus.wr_data;
      end
      case (state)
        IDLE: if (trigger) begin
          state     <= FETCH;
          i         <= LOG2_WPL'(1);
          fill_bank <= ~disp_bank;
        end
        FETCH: begin
          i <= i + 1'b1;
          if (&i) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 3'd1;
          if (drain_cnt == 3'(RD_LAT)) begin
            state      <= IDLE;
            line_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (wrap && line_ready) begin
        disp_bank  <= ~disp_bank;
        line_ready <= 1'b0;
      end
    end
  end
`ifdef FB_FETCH_CHECK_EN
  always_ff @(posedge vclock) begin
    if (reset) fetch_late <= 1'b0;
    else if (wrap && state != IDLE) fetch_late <= 1'b1;
  end
`else
  assign fetch_late = 1'b0;
`endif
endmodule

// File: tb/tb_fb_fetch_arbiter.sv
// tb_fb_fetch_arbiter: scoreboard bench for fb_fetch_arbiter driving its own xvga counters, writer and RAM model
module tb_fb_fetch_arbiter;
  localparam int ADDR_W = 20, DATA_W = 32, LOG2_WPL = 8, RD_LAT = 2, WPL = 256;
`ifdef FB_FETCH_CHECK_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif
  logic vclock = 1'b0, reset = 1'b1;
  logic [10:0] hcount = 11'd1020, vcount = 11'd805;
  logic disp_bank, fetch_late, disp_bank_l, fetch_late_l;
  always #5 vclock = ~vclock;
  fb_fetch_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOG2_WPL(LOG2_WPL)) bus ();
  fb_fetch_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOG2_WPL(LOG2_WPL)) bus_l ();
  fb_fetch_arbiter dut (
    .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount),
    .bus(bus), .disp_bank(disp_bank), .fetch_late(fetch_late)
  );
  fb_fetch_arbiter #(.FETCH_START(1200)) dut_l (
    .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount),
    .bus(bus_l), .disp_bank(disp_bank_l), .fetch_late(fetch_late_l)
  );
  function automatic logic [DATA_W-1:0] md(input logic [ADDR_W-1:0] a);
    return {12'h5A0, a};
  endfunction
  function automatic int next_line(input logic [10:0] v);
    return (v == 11'd805) ? 0 : int'(v) + 1;
  endfunction
  logic [ADDR_W-1:0] rp [RD_LAT];
  always @(posedge vclock) begin
    rp[0] <= bus.mem_addr;
    for (int k = 1; k < RD_LAT; k++) rp[k] <= rp[k-1];
  end
  assign bus.mem_rdata = md(rp[RD_LAT-1]);
  int tests = 0, fails = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (v=%0d h=%0d)", tag, got, exp, vcount, hcount);
    end
  endtask
  logic [40:0] lb_q[$];
  logic [51:0] wr_q[$];
  logic [40:0] e;
  logic [51:0] w;
  logic exp_disp = 1'b0, exp_ready = 1'b0, wr_on = 1'b0, meas = 1'b0;
  int jump = -1, wseq = 0, lb_cnt = 0, lb_first = -1, lb_last = -1;
  int lo = 0, first_lo = -1, last_lo = -1, ack_h = -1;
  always @(negedge vclock) if (!reset) begin
    check("disp_bank", disp_bank, exp_disp);
    if (bus.lb_we) begin
      lb_cnt++;
      if (lb_first < 0) lb_first = hcount;
      lb_last = hcount;
      if (lb_q.size() == 0) check("lb_extra", bus.lb_we, 0);
      else begin
        e = lb_q.pop_front();
        check("lb_waddr", bus.lb_waddr, e[40:32]);
        check("lb_wdata", bus.lb_wdata, e[31:0]);
      end
    end
    if (bus.mem_we) begin
      check("wr_ack_hi", bus.wr_ack, 1);
      if (ack_h < 0) ack_h = hcount;
      if (wr_q.size() == 0) check("wr_extra", bus.mem_we, 0);
      else begin
        w = wr_q.pop_front();
        check("wr_addr", bus.mem_addr, w[51:32]);
        check("wr_data", bus.mem_wdata, w[31:0]);
      end
    end else check("wr_ack_lo", bus.wr_ack, 0);
    if (meas && !bus.mem_we) begin
      if (first_lo < 0) first_lo = hcount;
      last_lo = hcount;
      lo++;
    end
  end
  task automatic present();
    wseq++;
    bus.wr_addr = 20'h80000 + 20'(wseq);
    bus.wr_data = 32'hC0DE0000 + 32'(wseq);
    bus.wr_req  = 1'b1;
    wr_q.push_back({bus.wr_addr, bus.wr_data});
  endtask
  task automatic step();
    @(posedge vclock);
    if (reset) begin
      exp_disp = 1'b0;
      exp_ready = 1'b0;
      lb_q.delete();
    end else begin
      if (hcount == 11'd1343 && exp_ready) begin
        exp_disp = ~exp_disp;
        exp_ready = 1'b0;
      end
      if (hcount == 11'd1024 && next_line(vcount) < 768) begin
        for (int k = 0; k < WPL; k++)
          lb_q.push_back({~exp_disp, 8'(k), md(20'(next_line(vcount) * WPL + k))});
        exp_ready = 1'b1;
      end
    end
    #1;
    if (bus.wr_ack) begin
      if (wr_on) present();
      else bus.wr_req = 1'b0;
    end
    if (hcount == 11'd1343) begin
      hcount = 11'd0;
      vcount = (jump >= 0) ? 11'(jump) : 11'(next_line(vcount));
      jump = -1;
    end else hcount++;
  endtask
  task automatic run_to(input int v, input int h);
    int n = 0;
    while ((vcount != 11'(v) || hcount != 11'(h)) && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) check("run_to_timeout", 1, 0);
  endtask
  int c0;
  logic d0;
  initial begin
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus_l.wr_req = 1'b0; bus_l.wr_addr = '0; bus_l.wr_data = '0; bus_l.mem_rdata = '0;
    repeat (3) step();
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_wr_ack", bus.wr_ack, 0);
    check("rst_lb_we", bus.lb_we, 0);
    check("rst_disp_bank", disp_bank, 0);
    check("rst_fetch_late", fetch_late_l, 0);
    reset = 1'b0;
    c0 = lb_cnt;
    lb_first = -1;
    step();
    step();
    check("first_rd_addr", bus.mem_addr, 0);
    check("first_rd_we", bus.mem_we, 0);
    run_to(805, 1280);
    check("last_rd_addr", bus.mem_addr, 255);
    run_to(805, 1343);
    check("disp_before_wrap", disp_bank, 0);
    check("lb_count", lb_cnt - c0, 256);
    check("lb_first_h", lb_first, 1027);
    check("lb_last_h", lb_last, 1282);
    step();
    check("disp_after_wrap", disp_bank, 1);
    step();
    check("fetch_late_ok", fetch_late, 0);
    check("fetch_late_lt", fetch_late_l, FL);
    jump = 8;
    run_to(8, 1300);
    wr_on = 1'b1;
    present();
    run_to(9, 0);
    meas = 1'b1;
    run_to(9, 1025);
    check("line10_addr", bus.mem_addr, 2560);
    run_to(10, 0);
    meas = 1'b0;
    wr_on = 1'b0;
    check("stall_len", lo, 259);
    check("stall_first", first_lo, 1025);
    check("stall_last", last_lo, 1283);
    run_to(10, 1024);
    ack_h = -1;
    present();
    run_to(10, 1300);
    check("trig_wr_ack_h", ack_h, 1284);
    jump = 766;
    run_to(767, 0);
    c0 = lb_cnt;
    d0 = exp_disp;
    jump = 803;
    run_to(805, 0);
    check("blank_no_lb", lb_cnt - c0, 0);
    check("blank_disp", disp_bank, d0);
    run_to(0, 0);
    check("resume_lb", lb_cnt - c0, 256);
    run_to(0, 1100);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_late_clr", fetch_late_l, 0);
    for (int k = 0; k <= RD_LAT; k++) begin
      check("rst_flush_lb", bus.lb_we, 0);
      check("rst_flush_we", bus.mem_we, 0);
      step();
    end
    run_to(1, 1);
    check("rst_no_toggle", disp_bank, 0);
    check("lb_q_empty", lb_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
